// File: rtl/bambu_io_pkg.sv
// Shared constants and FSM encoding for the putchar arbiter.
// Round-robin arbitration is selected with BAMBU_ARB_ROUND_ROBIN_EN.
package bambu_io_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned RetW        = 16;
  localparam int unsigned NreqDefault = 4;

endpackage

// File: rtl/bambu_rr_pick.sv
// Picks the first pending index searching upward from ptr_i+1 with wrap-around.
// A constant pointer of NREQ-1 turns this into lowest-index-wins.
module bambu_rr_pick
  import bambu_io_pkg::*;
#(
  parameter int unsigned NREQ = NreqDefault,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] pending_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] winner_o,
  output logic            valid_o
);

  logic [31:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr_i) + k) % NREQ;
      if (!valid_o && pending_i[idx[IdxW-1:0]]) begin
        valid_o  = 1'b1;
        winner_o = idx[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/bambu_putchar_arbiter.sv
// Shares one UART TX channel among NREQ HLS putchar call sites.
// Define BAMBU_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module bambu_putchar_arbiter
  import bambu_io_pkg::*;
#(
  parameter int unsigned NREQ = NreqDefault,
  parameter int unsigned DW   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      start_port,
  input  logic [NREQ*DW-1:0]   data_port,
  output logic [NREQ-1:0]      done_port,
  output logic [NREQ*RetW-1:0] return_port,
  output logic [DW-1:0]        TX_DATA,
  output logic                 TX_VALID,
  input  logic                 TX_READY
);

  localparam int unsigned IdxW = $clog2(NREQ);

  state_e                       state_q;
  logic [NREQ-1:0]              pending_q, pending_d, accept;
  logic [NREQ-1:0][DW-1:0]      char_q;
  logic [NREQ-1:0][RetW-1:0]    ret_q;
  logic [NREQ-1:0]              done_q;
  logic [DW-1:0]                tx_data_q;
  logic                         tx_valid_q;
  logic [IdxW-1:0]              grant_q, ptr, winner;
  logic                         win_valid;

  // The granted requester may re-call in its own DONE cycle.
  always_comb begin
    accept    = '0;
    pending_d = pending_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      accept[i] = start_port[i] &&
                  (!pending_q[i] || (state_q == StDone && grant_q == IdxW'(i)));
    end
    if (state_q == StDone) pending_d[grant_q] = 1'b0;
    pending_d = pending_d | accept;
  end

`ifdef BAMBU_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= IdxW'(NREQ - 1);
    end else if (state_q == StIdle && win_valid) begin
      ptr_q <= winner;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = IdxW'(NREQ - 1);
`endif

  bambu_rr_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_pick (
    .pending_i (pending_q),
    .ptr_i     (ptr),
    .winner_o  (winner),
    .valid_o   (win_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      char_q     <= '0;
      ret_q      <= '0;
      done_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      grant_q    <= '0;
    end else begin
      pending_q <= pending_d;
      done_q    <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (accept[i]) char_q[i] <= data_port[i*DW +: DW];
      end
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            tx_data_q  <= char_q[winner];
            tx_valid_q <= 1'b1;
            grant_q    <= winner;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (TX_READY) begin
            tx_valid_q     <= 1'b0;
            done_q[grant_q] <= 1'b1;
            ret_q[grant_q]  <= RetW'(tx_data_q);
            state_q        <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done_port   = done_q;
  assign return_port = ret_q;
  assign TX_DATA     = tx_data_q;
  assign TX_VALID    = tx_valid_q;

endmodule

// File: tb/tb_bambu_putchar_arbiter.sv
// Directed bench for bambu_putchar_arbiter: a cycle table plus multi-cycle sequences.
module tb_bambu_putchar_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  start_port = '0;
  logic [31:0] data_port = '0;
  logic [3:0]  done_port;
  logic [63:0] return_port;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  bambu_putchar_arbiter #(
    .NREQ (4),
    .DW   (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_port  (start_port),
    .data_port   (data_port),
    .done_port   (done_port),
    .return_port (return_port),
    .TX_DATA     (TX_DATA),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  start;
    logic [31:0] data;
    logic        rdy;
    logic        ev;
    logic [7:0]  etxd;
    logic [3:0]  edone;
    logic [63:0] eret;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    check("done_onehot", 64'($countones(done_port) <= 1), 64'd1);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    start_port = '0;
    data_port  = '0;
    TX_READY   = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic call(input logic [3:0] s, input logic [31:0] d);
    start_port = s;
    data_port  = d;
    step();
    start_port = '0;
  endtask

  // Returns at the cycle where a done pulse is visible; d is the character handed off.
  task automatic wait_done(output logic [7:0] d, output int idx);
    d   = '0;
    idx = -1;
    for (int k = 0; k < 60; k++) begin
      if (TX_VALID && TX_READY) d = TX_DATA;
      step();
      if (done_port != 0) begin
        for (int i = 0; i < 4; i++) if (done_port[i]) idx = i;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_done: got no done pulse expected one within 60 cycles");
  endtask

  initial begin
    logic [7:0] d;
    int         idx;
    logic [7:0] chars;

    // Single call then backpressured call; rows: start, data, rdy, exp valid/data/done/return.
    tbl[0]  = '{4'b0001, 32'h0000_0041, 1'b1, 1'b0, 8'h00, 4'b0000, 64'h0};
    tbl[1]  = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h00, 4'b0000, 64'h0};
    tbl[2]  = '{4'b0000, 32'h0,         1'b1, 1'b1, 8'h41, 4'b0000, 64'h0};
    tbl[3]  = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h41, 4'b0001, 64'h41};
    tbl[4]  = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h41, 4'b0000, 64'h41};
    tbl[5]  = '{4'b0100, 32'h007E_0000, 1'b0, 1'b0, 8'h41, 4'b0000, 64'h41};
    tbl[6]  = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h41, 4'b0000, 64'h41};
    tbl[7]  = '{4'b0000, 32'h0,         1'b0, 1'b1, 8'h7E, 4'b0000, 64'h41};
    tbl[8]  = '{4'b0100, 32'h0011_0000, 1'b0, 1'b1, 8'h7E, 4'b0000, 64'h41};
    tbl[9]  = '{4'b0000, 32'h0,         1'b0, 1'b1, 8'h7E, 4'b0000, 64'h41};
    tbl[10] = '{4'b0000, 32'h0,         1'b0, 1'b1, 8'h7E, 4'b0000, 64'h41};
    tbl[11] = '{4'b0000, 32'h0,         1'b0, 1'b1, 8'h7E, 4'b0000, 64'h41};
    tbl[12] = '{4'b0000, 32'h0,         1'b1, 1'b1, 8'h7E, 4'b0000, 64'h41};
    tbl[13] = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h7E, 4'b0100, 64'h0000_007E_0000_0041};
    tbl[14] = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h7E, 4'b0000, 64'h0000_007E_0000_0041};
    tbl[15] = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h7E, 4'b0000, 64'h0000_007E_0000_0041};
    tbl[16] = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h7E, 4'b0000, 64'h0000_007E_0000_0041};

    do_reset();
    check("reset_valid", 64'(TX_VALID), 64'd0);
    check("reset_data", 64'(TX_DATA), 64'd0);
    check("reset_done", 64'(done_port), 64'd0);
    check("reset_ret", return_port, 64'd0);

    for (int r = 0; r < 17; r++) begin
      start_port = tbl[r].start;
      data_port  = tbl[r].data;
      TX_READY   = tbl[r].rdy;
      check($sformatf("tbl%0d_valid", r), 64'(TX_VALID), 64'(tbl[r].ev));
      check($sformatf("tbl%0d_data", r), 64'(TX_DATA), 64'(tbl[r].etxd));
      check($sformatf("tbl%0d_done", r), 64'(done_port), 64'(tbl[r].edone));
      check($sformatf("tbl%0d_ret", r), return_port, tbl[r].eret);
      step();
    end
    start_port = '0;
    TX_READY   = 1'b1;

    // Simultaneous calls from all four requesters: 'a','b','c','d' in index order.
    do_reset();
    call(4'b1111, 32'h6463_6261);
    for (int k = 0; k < 4; k++) begin
      wait_done(d, idx);
      chars = 8'h61 + 8'(k);
      check($sformatf("all4_char%0d", k), 64'(d), 64'(chars));
      check($sformatf("all4_idx%0d", k), 64'(idx), 64'(k));
    end
    check("all4_ret", return_port, 64'h0064_0063_0062_0061);

    // Requesters 0 and 2 re-call on every completion.
    do_reset();
    call(4'b0101, 32'h0022_0020);
    for (int k = 0; k < 4; k++) begin
      wait_done(d, idx);
`ifdef BAMBU_ARB_ROUND_ROBIN_EN
      check($sformatf("fair_idx%0d", k), 64'(idx), (k % 2 == 0) ? 64'd0 : 64'd2);
`else
      check($sformatf("fair_idx%0d", k), 64'(idx), 64'd0);
`endif
      if (idx >= 0) call(4'(1 << idx), 32'h0022_0020);
    end
    wait_done(d, idx);
    check("fair_drain0", 64'(idx), 64'd0);
    wait_done(d, idx);
    check("fair_drain2", 64'(idx), 64'd2);
    check("fair_drain2_char", 64'(d), 64'h22);

    // New call from requester 1 in the same cycle as its done pulse.
    call(4'b0010, 32'h0000_3300);
    wait_done(d, idx);
    check("restart_first_char", 64'(d), 64'h33);
    check("restart_first_idx", 64'(idx), 64'd1);
    call(4'b0010, 32'h0000_5A00);
    wait_done(d, idx);
    check("restart_second_char", 64'(d), 64'h5A);
    check("restart_second_idx", 64'(idx), 64'd1);
    check("restart_ret1", 64'(return_port[31:16]), 64'h005A);

    // Reset while the transmitter is stalled.
    TX_READY = 1'b0;
    call(4'b0001, 32'h0000_0088);
    begin
      int k;
      for (k = 0; k < 10 && !TX_VALID; k++) step();
      check("midsend_valid_rose", 64'(TX_VALID), 64'd1);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midsend_valid_dropped", 64'(TX_VALID), 64'd0);
    check("midsend_no_done", 64'(done_port), 64'd0);
    check("midsend_data_cleared", 64'(TX_DATA), 64'd0);
    TX_READY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("midsend_idle%0d", k), {59'd0, TX_VALID, done_port}, 64'd0);
    end
    call(4'b0001, 32'h0000_0099);
    wait_done(d, idx);
    check("after_reset_char", 64'(d), 64'h99);
    check("after_reset_idx", 64'(idx), 64'd0);
    check("after_reset_ret", return_port, 64'h0000_0000_0000_0099);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
